// File: rtl/led_fader_pkg.sv
// led_fader_pkg: shared defaults and helpers for the LED PWM fader.
//   NUM_LEDS_DEF / PWM_BITS_DEF / STEP_DIV_DEF : default top-level parameters
//   pwm_max()   : full-scale brightness for a given PWM width
//   gamma_map() : square-law brightness curve used when LED_FADER_GAMMA_EN is defined
package led_fader_pkg;

  localparam int NUM_LEDS_DEF = 10;
  localparam int PWM_BITS_DEF = 8;
  localparam int STEP_DIV_DEF = 1024;

  function automatic int unsigned pwm_max(input int unsigned bits);
    return (32'd1 << bits) - 32'd1;
  endfunction

  // Square law, truncated to bits; full scale is pinned so the top level
  // still drives the pin constantly on. Valid for bits <= 16.
  function automatic int unsigned gamma_map(input int unsigned lvl, input int unsigned bits);
    int unsigned max_v;
    max_v = pwm_max(bits);
    if (lvl == max_v) return max_v;
    return (lvl * lvl) >> bits;
  endfunction

endpackage

// File: rtl/led_fader_channel.sv
// led_fader_channel: one LED's brightness ramp and PWM compare.
//   clk, reset     : clock, synchronous active-high reset
//   tgt_i          : on/off target (1 = full scale)
//   fade_en_i      : 1 = ramp on step ticks, 0 = snap to target every cycle
//   step_tick_i    : prescaled ramp strobe
//   pwm_cnt_i      : shared PWM phase counter
//   led_o          : registered PWM drive
//   mismatch_o     : level differs from target (combinational, feeds busy)
// Optional: LED_FADER_GAMMA_EN adds a registered gamma-mapped duty stage.
module led_fader_channel
  import led_fader_pkg::*;
#(
  parameter int PWM_BITS = PWM_BITS_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                tgt_i,
  input  logic                fade_en_i,
  input  logic                step_tick_i,
  input  logic [PWM_BITS-1:0] pwm_cnt_i,
  output logic                led_o,
  output logic                mismatch_o
);

  localparam logic [PWM_BITS-1:0] MAX = PWM_BITS'(pwm_max(PWM_BITS));

  logic [PWM_BITS-1:0] level_q, level_d, tgt_lvl, duty;
  logic                led_q, led_d;

  assign tgt_lvl    = tgt_i ? MAX : '0;
  assign mismatch_o = (level_q != tgt_lvl);

  // Three-way ramp: up, down or hold; saturating at both ends.
  always_comb begin
    level_d = level_q;
    if (!fade_en_i) begin
      level_d = tgt_lvl;
    end else if (step_tick_i) begin
      if (tgt_i && level_q != MAX)       level_d = level_q + PWM_BITS'(1);
      else if (!tgt_i && level_q != '0)  level_d = level_q - PWM_BITS'(1);
    end
  end

`ifdef LED_FADER_GAMMA_EN
  logic [PWM_BITS-1:0] duty_q;
  always_ff @(posedge clk) begin
    if (reset) duty_q <= '0;
    else       duty_q <= PWM_BITS'(gamma_map(32'(level_q), PWM_BITS));
  end
  assign duty = duty_q;
`else
  assign duty = level_q;
`endif

  // pwm_cnt never reaches MAX, so duty == MAX is solidly on.
  assign led_d = (duty > pwm_cnt_i);

  always_ff @(posedge clk) begin
    if (reset) begin
      level_q <= '0;
      led_q   <= 1'b0;
    end else begin
      level_q <= level_d;
      led_q   <= led_d;
    end
  end

  assign led_o = led_q;

endmodule

// File: rtl/led_fader.sv
// led_fader: PWM fader between the LED output register and the board pins.
//   clk, reset : clock, synchronous active-high reset
//   led_in     : per-LED on/off targets
//   fade_en    : 1 = linear ramps, 0 = snap to target
//   led_out    : registered PWM pin drive
//   busy       : registered, 1 while any level differs from its target
// Optional: LED_FADER_GAMMA_EN (adds gamma-mapped duty, one extra cycle latency).
module led_fader
  import led_fader_pkg::*;
#(
  parameter int NUM_LEDS = NUM_LEDS_DEF,
  parameter int PWM_BITS = PWM_BITS_DEF,
  parameter int STEP_DIV = STEP_DIV_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_LEDS-1:0] led_in,
  input  logic                fade_en,
  output logic [NUM_LEDS-1:0] led_out,
  output logic                busy
);

  localparam logic [PWM_BITS-1:0] MAX      = PWM_BITS'(pwm_max(PWM_BITS));
  localparam int                  DIV_W    = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [DIV_W-1:0]    DIV_LAST = DIV_W'(STEP_DIV - 1);

  logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
  logic [DIV_W-1:0]    div_cnt_q, div_cnt_d;
  logic                step_tick;
  logic                busy_q, busy_d;
  logic [NUM_LEDS-1:0] mismatch;

  // With STEP_DIV == 1 the counter sits at 0 and ticks every cycle.
  assign step_tick = (div_cnt_q == DIV_LAST);
  assign div_cnt_d = step_tick ? '0 : div_cnt_q + DIV_W'(1);
  // Period MAX (not MAX+1) so that full-scale duty never drops out.
  assign pwm_cnt_d = (pwm_cnt_q == MAX - PWM_BITS'(1)) ? '0 : pwm_cnt_q + PWM_BITS'(1);
  assign busy_d    = |mismatch;

  always_ff @(posedge clk) begin
    if (reset) begin
      pwm_cnt_q <= '0;
      div_cnt_q <= '0;
      busy_q    <= 1'b0;
    end else begin
      pwm_cnt_q <= pwm_cnt_d;
      div_cnt_q <= div_cnt_d;
      busy_q    <= busy_d;
    end
  end

  for (genvar i = 0; i < NUM_LEDS; i++) begin : g_ch
    led_fader_channel #(.PWM_BITS(PWM_BITS)) u_ch (
      .clk        (clk),
      .reset      (reset),
      .tgt_i      (led_in[i]),
      .fade_en_i  (fade_en),
      .step_tick_i(step_tick),
      .pwm_cnt_i  (pwm_cnt_q),
      .led_o      (led_out[i]),
      .mismatch_o (mismatch[i])
    );
  end

  assign busy = busy_q;

endmodule

// File: tb/tb_led_fader.sv
// tb_led_fader: directed bench for led_fader.
// u_dut runs with STEP_DIV=4; u_slow uses STEP_DIV=256 so a level stays
// constant for a full PWM period, letting duty be measured by counting.
module tb_led_fader;

`ifdef LED_FADER_GAMMA_EN
  localparam int LAT   = 2;
  localparam int EXP15 = 0;
  localparam int EXP128 = 64;
`else
  localparam int LAT   = 1;
  localparam int EXP15 = 15;
  localparam int EXP128 = 128;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, fade_en, busy;
  logic [9:0] led_in, led_out;
  logic       reset_s, fade_en_s, busy_s;
  logic [9:0] led_in_s, led_out_s;

  led_fader #(.NUM_LEDS(10), .PWM_BITS(8), .STEP_DIV(4)) u_dut (
    .clk(clk), .reset(reset), .led_in(led_in), .fade_en(fade_en),
    .led_out(led_out), .busy(busy)
  );

  led_fader #(.NUM_LEDS(10), .PWM_BITS(8), .STEP_DIV(256)) u_slow (
    .clk(clk), .reset(reset_s), .led_in(led_in_s), .fade_en(fade_en_s),
    .led_out(led_out_s), .busy(busy_s)
  );

  logic [7:0] lvl0, lvl9, lvl0_s;
  assign lvl0   = u_dut.g_ch[0].u_ch.level_q;
  assign lvl9   = u_dut.g_ch[9].u_ch.level_q;
  assign lvl0_s = u_slow.g_ch[0].u_ch.level_q;

  int ncmp = 0;
  int nfail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one cycle; return at the negedge so outputs are stable.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    int nbusy, first255, nz, hi, bad;
    logic [7:0] prev;

    reset = 1'b1; fade_en = 1'b1; led_in = 10'h3FF;
    reset_s = 1'b1; fade_en_s = 1'b1; led_in_s = 10'h001;

    // 1. Reset held 3 cycles with all targets on
    for (int c = 0; c < 3; c++) begin
      step();
      chk("rst_led",  32'(led_out), 32'h0);
      chk("rst_busy", 32'(busy),    32'h0);
      chk("rst_lvl0", 32'(lvl0),    32'h0);
      chk("rst_lvl9", 32'(lvl9),    32'h0);
    end

    // 2. Snap mode
    reset = 1'b0; fade_en = 1'b0; led_in = 10'h2A5;
    step();
    chk("snap_led_c1",  32'(led_out), 32'h0);
    chk("snap_busy_c1", 32'(busy),    32'h1);
    for (int n = 2; n <= 20; n++) begin
      step();
      if (n > LAT) chk("snap_led", 32'(led_out), 32'h2A5);
      chk("snap_busy", 32'(busy), 32'h0);
    end

    // 3. Full fade up of LED0 from zero
    reset = 1'b1; step();
    chk("fade_rst_lvl0", 32'(lvl0), 32'h0);
    reset = 1'b0; fade_en = 1'b1; led_in = 10'h001;
    nbusy = 0; first255 = 0; nz = 0;
    for (int n = 1; n <= 1030; n++) begin
      step();
      if (n == 1) chk("fade_busy_rise", 32'(busy), 32'h1);
      if (n == 3) chk("fade_pre_tick",  32'(lvl0), 32'h0);
      if (n == 4) chk("fade_first_tick", 32'(lvl0), 32'h1);
      if (busy) nbusy++;
      if (lvl0 == 8'd255 && first255 == 0) first255 = n;
      if (led_out[9:1] != 9'h0) nz++;
    end
    chk("fade_busy_cycles", 32'(nbusy),    32'd1020);
    chk("fade_reach_255",   32'(first255), 32'd1020);
    chk("fade_others_off",  32'(nz),       32'd0);
    chk("fade_busy_end",    32'(busy),     32'h0);
    hi = 0;
    for (int n = 0; n < 255; n++) begin
      step();
      hi = hi + int'(led_out[0]);
    end
    chk("duty_255", 32'(hi), 32'd255);

    // 4. Reversal at level 100
    reset = 1'b1; step();
    reset = 1'b0; led_in = 10'h001;
    for (int n = 1; n <= 400; n++) step();
    chk("rev_at_100", 32'(lvl0), 32'd100);
    led_in = 10'h000;
    for (int n = 401; n <= 403; n++) step();
    chk("rev_hold", 32'(lvl0), 32'd100);
    step();
    chk("rev_first", 32'(lvl0), 32'd99);
    chk("rev_busy",  32'(busy), 32'h1);
    bad = 0; prev = lvl0;
    for (int n = 405; n <= 800; n++) begin
      step();
      if (lvl0 != prev && lvl0 != prev - 8'd1) bad++;
      prev = lvl0;
      if (n == 799) chk("rev_lvl_799", 32'(lvl0), 32'd1);
    end
    chk("rev_no_jump", 32'(bad),  32'd0);
    chk("rev_zero",    32'(lvl0), 32'd0);
    chk("rev_busy_800", 32'(busy), 32'h1);
    step();
    chk("rev_busy_fall", 32'(busy), 32'h0);

    // 5. Reset mid-fade at level 60
    reset = 1'b1; step();
    reset = 1'b0; led_in = 10'h001;
    for (int n = 1; n <= 240; n++) step();
    chk("mid_at_60", 32'(lvl0), 32'd60);
    reset = 1'b1;
    step();
    chk("mid_rst_lvl",  32'(lvl0),    32'd0);
    chk("mid_rst_led",  32'(led_out), 32'h0);
    chk("mid_rst_busy", 32'(busy),    32'h0);
    reset = 1'b0; led_in = 10'h000;

    // 6. Duty measurement on the slow instance (levels 15 and 128)
    reset_s = 1'b0;
    hi = 0; nz = 0;
    for (int n = 1; n <= 4096; n++) begin
      step();
      if (n == 3840) chk("slow_lvl15", 32'(lvl0_s), 32'd15);
      if (n >= 3842) hi = hi + int'(led_out_s[0]);
      if (led_out_s[9:1] != 9'h0) nz++;
    end
    chk("duty_15", 32'(hi), 32'(EXP15));
    hi = 0;
    for (int n = 4097; n <= 33024; n++) begin
      step();
      if (n == 32768) chk("slow_lvl128", 32'(lvl0_s), 32'd128);
      if (n >= 32770) hi = hi + int'(led_out_s[0]);
      if (led_out_s[9:1] != 9'h0) nz++;
    end
    chk("duty_128",        32'(hi), 32'(EXP128));
    chk("slow_others_off", 32'(nz), 32'd0);
    chk("slow_busy",       32'(busy_s), 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule

// File: doc/led_fader.md
# led_fader

Downstream output stage for the 10-bit LED parallel-output register. Takes the register's `out_port` value as per-LED on/off targets and drives the physical LED pins with PWM. Each LED ramps its brightness linearly toward its target, so register writes produce smooth fades instead of hard switching. Sits between the LED output port and the board LED pins.

## Interface
- `NUM_LEDS`, default 10: number of LED channels.
- `PWM_BITS`, default 8: width of the brightness level and PWM counter. `MAX = 2^PWM_BITS - 1`.
- `STEP_DIV`, default 1024: clock cycles per fade step. Legal range is ≥ 1.

- `clk`, input, 1: system clock. One clock domain.
- `reset`, input, 1: synchronous, active-high reset.
- `led_in`, input, `NUM_LEDS`: target pattern taken from the LED output register. 1 means target `MAX`; 0 means target 0.
- `fade_en`, input, 1: 1 selects ramped levels; 0 makes levels snap to target.
- `led_out`, output, `NUM_LEDS`: PWM drive to the pins. Registered.
- `busy`, output, 1: 1 while any channel level differs from its target. Registered.

## Operation
- **PWM counter `pwm_cnt`** (`PWM_BITS` wide)
  - Counts 0 → `MAX-1`, then wraps to 0. Period is `MAX` cycles (255 at default).
- **Step prescaler `div_cnt`**
  - Counts 0 → `STEP_DIV-1` and wraps.
  - `step_tick` = 1 on the cycle `div_cnt == STEP_DIV-1`.
  - With `STEP_DIV = 1`, `step_tick` is 1 every cycle.
- **Per-channel level `level[i]`**, when `fade_en = 1`, on `step_tick` only:
  - `led_in[i] = 1` and `level < MAX`: `level + 1`.
  - `led_in[i] = 0` and `level > 0`: `level - 1`.
  - Otherwise the level holds. It saturates at both ends and never wraps.
- **`fade_en = 0`**: every cycle, `level[i] <= led_in[i] ? MAX : 0`. The prescaler and PWM counter keep running.
- **Target reversal mid-ramp**: the ramp reverses from the current level with no jump.
- **Asynchronous `led_in` changes**: `led_in` comes from a register in the same clock domain, so no synchroniser is used.
- **Duty value `duty[i]`**
  - Equals `level[i]`, or the gamma-mapped value (see Configuration).
- **Output**: `led_out[i] <= (duty[i] > pwm_cnt)`.
  - `duty = 0` gives constant 0.
  - `duty = MAX` gives constant 1, because `pwm_cnt` never reaches `MAX`.
- **`busy`**: `busy <=` OR over all `i` of `(level[i] != (led_in[i] ? MAX : 0))`.
- **Reset**
  - `pwm_cnt`, `div_cnt` and all `level` = 0.
  - `led_out = 0` and `busy = 0` on the cycle after `reset` is sampled high.
  - Reset mid-fade discards all levels. No ramp-down occurs.
- **No state machine beyond counters.** Each channel is a three-way ramp: up, down, or hold.

## Timing
- **Level to `led_out`**: 1 cycle. `led_out` reflects `level` registered on the previous edge.
- **`led_in` edge to first level change**: 1 to `STEP_DIV` cycles, depending on the prescaler phase.
- **Full fade 0 → `MAX`**: `MAX` ticks, which is `MAX·STEP_DIV` cycles (255·1024 = 261,120 at default) ± one prescaler phase.
- **`fade_en = 0` snap**: the level updates on the next edge, and `led_out` follows one cycle later.
- **`busy` timing**
  - Rises one cycle after a target mismatch appears.
  - Falls one cycle after the last level reaches its target.
- **Simultaneous `step_tick` and target reversal**: the step uses the new `led_in` value sampled on that edge.

## Configuration
- Macro `LED_FADER_GAMMA_EN`.
- **Defined**: `duty[i] = (level[i] == MAX) ? MAX : (level[i] * level[i]) >> PWM_BITS`.
  - The product is a `2·PWM_BITS`-bit intermediate, and the result is truncated to `PWM_BITS`.
  - This gives a perceptually linear fade.
  - One pipeline register is added to `duty`, making level → `led_out` 2 cycles.
- **Undefined**: `duty[i] = level[i]`, with 1-cycle latency and no multipliers.

## Structure
- **Package `led_fader_pkg`** holds:
  - the default constants `NUM_LEDS`, `PWM_BITS` and `STEP_DIV`;
  - a function computing `MAX` from `PWM_BITS`;
  - the gamma function.
- **Sub-module `led_fader_channel`** holds one channel's level register, ramp logic, optional gamma map and output compare. It is instantiated `NUM_LEDS` times via generate.
- **Top level** holds `pwm_cnt`, `div_cnt` and the `busy` reduction.

## Test plan
Bench parameters: `STEP_DIV = 4`, `PWM_BITS = 8` unless stated.

1. **Reset**: hold `reset` for 3 cycles with `led_in = 10'h3FF`. Required: `led_out = 0` and `busy = 0` during reset and on the cycle after. All levels read 0.
2. **Snap**: set `fade_en = 0` and `led_in = 10'h2A5`. Required: `led_out = 10'h2A5` continuously from cycle 2 onward, and `busy = 0` from cycle 2 onward.
3. **Fade up**: set `fade_en = 1` and `led_in = 10'h001` from all levels 0.
   - `busy = 1` for about 1020 cycles, and `level[0]` reaches 255 at about cycle 1020.
   - At `level[0] = 128`, `led_out[0]` is high exactly 128 of 255 cycles.
   - `led_out[9:1] = 0` throughout.
4. **Reversal**: during test 3, drop `led_in[0]` to 0 at `level[0] = 100`. Required: the next tick gives 99 with no jump, and the level descends to 0 with `busy` deasserting afterward.
5. **Reset mid-fade**: assert `reset` at `level[0] = 60`. Required: the level is 0 and `led_out = 0` on the next cycle.
6. **Gamma** (with `LED_FADER_GAMMA_EN`):
   - `level = 128` gives duty 64 (64 of 255 cycles high).
   - `level = 255` gives constant 1.
   - `level = 15` gives duty 0.
